// File: rtl/rib_uart_tx.sv
// Transmit-only 8N1 UART on a RIB slave port: four memory-mapped registers,
// a small TX FIFO and a serializer running at a programmable bit period.
module rib_uart_tx #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] BAUD_RST   = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  input  logic        we_i,
  output logic        tx_o,
  output logic        irq_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_STATUS = 2'd1,
    REG_BAUD   = 2'd2,
    REG_TXDATA = 2'd3
  } reg_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  reg_e reg_sel;
  assign reg_sel = reg_e'(addr_i[3:2]);

  // Register file
  logic [1:0]  ctrl_q;
  logic        ovf_q;
  logic [15:0] baud_q;
  logic        tx_en;
  logic        irq_en;

  assign tx_en  = ctrl_q[0];
  assign irq_en = ctrl_q[1];

  // FIFO
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             full;
  logic             empty;
  logic             push_req;
  logic             push_ok;
  logic             pop;
  logic [3:0]       level_nib;

  assign full     = (level_q == FULL_LVL);
  assign empty    = (level_q == '0);
  assign push_req = we_i && (reg_sel == REG_TXDATA);
  // A full FIFO still accepts a push when the serializer frees a slot this cycle.
  assign push_ok  = push_req && (!full || pop);

  if (LVL_W > 4) begin : g_level_sat
    assign level_nib = (|level_q[LVL_W-1:4]) ? 4'hF : level_q[3:0];
  end else begin : g_level_ext
    assign level_nib = 4'(level_q);
  end

  // Serializer
  state_e      state_q;
  state_e      state_d;
  logic [7:0]  byte_q;
  logic [2:0]  bit_idx_q;
  logic [15:0] cnt_q;
  logic [15:0] period_q;
  logic [15:0] baud_eff;
  logic        bit_end;
  logic        tx_d;
  logic        busy;

  assign baud_eff = (baud_q < 16'd2) ? 16'd2 : baud_q;
  assign bit_end  = (cnt_q == period_q - 16'd1);
  assign busy     = (state_q != IDLE);

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    tx_d    = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (tx_en && !empty) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        tx_d = byte_q[bit_idx_q];
        if (bit_end && bit_idx_q == 3'd7) state_d = STOP;
      end
      STOP: begin
        if (bit_end) begin
          if (tx_en && !empty) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // tx_d follows the current state, so tx_o lags the state by one cycle and
  // the start bit appears the cycle after the pop edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_o      <= 1'b1;
      byte_q    <= '0;
      bit_idx_q <= '0;
      cnt_q     <= '0;
      period_q  <= BAUD_RST;
    end else begin
      tx_o <= tx_d;
      if (pop) begin
        byte_q    <= mem[rd_ptr_q];
        period_q  <= baud_eff;
        cnt_q     <= '0;
        bit_idx_q <= '0;
      end else if (busy) begin
        if (bit_end) begin
          cnt_q <= '0;
          if (state_q == DATA) bit_idx_q <= bit_idx_q + 3'd1;
        end else begin
          cnt_q <= cnt_q + 16'd1;
        end
      end
    end
  end

  // NOTE: the FIFO storage has no reset; the pointers and level define which
  // entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (rst && push_ok) mem[wr_ptr_q] <= data_i[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({push_ok, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl_q <= '0;
      ovf_q  <= 1'b0;
      baud_q <= BAUD_RST;
    end else begin
      if (we_i && reg_sel == REG_CTRL) ctrl_q <= data_i[1:0];
      if (we_i && reg_sel == REG_BAUD) baud_q <= data_i[15:0];
      if (push_req && full && !pop) begin
        ovf_q <= 1'b1;
      end else if (we_i && reg_sel == REG_STATUS && data_i[3]) begin
        ovf_q <= 1'b0;
      end
    end
  end

  always_comb begin
    data_o = '0;
    unique case (reg_sel)
      REG_CTRL:   data_o = {30'd0, ctrl_q};
      REG_STATUS: data_o = {24'd0, level_nib, ovf_q, empty, full, busy};
      REG_BAUD:   data_o = {16'd0, baud_q};
      REG_TXDATA: data_o = '0;
      default:    data_o = '0;
    endcase
  end

  assign irq_o = irq_en && empty && !busy;

  logic unused_bits;
  assign unused_bits = ^{addr_i[31:4], addr_i[1:0], data_i[31:16]};

endmodule

// File: tb/tb_rib_uart_tx.sv
// Self-checking bench for rib_uart_tx: a line monitor decodes frames from tx_o
// and compares them against a scoreboard of expected bytes and bit periods.
module tb_rib_uart_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] data_i = '0;
  logic [31:0] data_o;
  logic        we_i = 1'b0;
  logic        tx_o;
  logic        irq_o;

  rib_uart_tx #(.FIFO_DEPTH(8), .BAUD_RST(16'd434)) dut (
    .clk    (clk),
    .rst    (rst),
    .addr_i (addr_i),
    .data_i (data_i),
    .data_o (data_o),
    .we_i   (we_i),
    .tx_o   (tx_o),
    .irq_o  (irq_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         period;
  } frame_t;

  frame_t sb[$];
  int     start_log[$];
  int     frames_started = 0;
  int     frames_done    = 0;
  int     n_cmp = 0;
  int     n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr_i = a;
    data_i = d;
    we_i   = 1'b1;
    sync();
    we_i   = 1'b0;
    addr_i = '0;
    data_i = '0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr_i = a;
    @(negedge clk);
    d = data_o;
    sync();
    addr_i = '0;
  endtask

  task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    check(tag, d, exp);
  endtask

  task automatic push_byte(input logic [7:0] b, input int period, input bit sent);
    frame_t e;
    e.data   = b;
    e.period = period;
    if (sent) sb.push_back(e);
    wr(32'hC, {24'd0, b});
  endtask

  task automatic wait_start(input int target, input int budget);
    int k = 0;
    while (frames_started < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("wait_start", frames_started, target);
    sync();
  endtask

  task automatic wait_done(input int target, input int budget);
    int k = 0;
    while (frames_done < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("wait_frames", frames_done, target);
    sync();
  endtask

  // Line monitor: a low level while out of reset marks a start bit; every
  // cycle of the frame is compared with the ideal waveform for its period.
  initial begin : monitor
    frame_t     e;
    int         glitches;
    int         p;
    int         bi;
    logic [7:0] obs;
    logic       exp_bit;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && tx_o === 1'b0) begin
        start_log.push_back(cyc);
        frames_started++;
        check("frame_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
        end else begin
          e.data   = 8'h00;
          e.period = 2;
        end
        p        = e.period;
        glitches = 0;
        obs      = '0;
        aborted  = 1'b0;
        for (int i = 0; i < 10 * p; i++) begin
          if (i > 0) @(negedge clk);
          if (rst !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          bi = i / p;
          if (bi == 0)      exp_bit = 1'b0;
          else if (bi == 9) exp_bit = 1'b1;
          else              exp_bit = e.data[bi-1];
          if (tx_o !== exp_bit) glitches++;
          if (i % p == p / 2 && bi >= 1 && bi <= 8) obs[bi-1] = tx_o;
        end
        if (!aborted) begin
          check("frame_data", {24'd0, obs}, {24'd0, e.data});
          check("frame_timing", glitches, 0);
          frames_done++;
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin : stim
    int          wr_cyc;
    int          busy_cnt;
    int          irq_bad;
    int          n0;
    int          d0;
    bit          seen;
    logic [31:0] d;

    // Reset and register defaults
    rst = 1'b0;
    repeat (2) sync();
    rst = 1'b1;
    rd_check("rst_status", 32'h4, 32'h0000_0004);
    rd_check("rst_baud", 32'h8, 32'h0000_01B2);
    rd_check("rst_ctrl", 32'h0, 32'h0);
    rd_check("rst_txdata", 32'hC, 32'h0);
    rd_check("baud_alias", 32'h0ABC_DE18, 32'h0000_01B2);
    @(negedge clk);
    check("rst_tx", tx_o, 1'b1);
    check("rst_irq", irq_o, 1'b0);
    sync();

    // Single frame: latency and busy length
    wr(32'h8, 32'd4);
    wr(32'h0, 32'd1);
    push_byte(8'hA5, 4, 1'b1);
    wr_cyc   = cyc;
    addr_i   = 32'h4;
    busy_cnt = 0;
    seen     = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (data_o[0]) begin
        busy_cnt++;
        seen = 1'b1;
      end else if (seen) begin
        break;
      end
    end
    sync();
    addr_i = '0;
    check("busy_cycles", busy_cnt, 40);
    wait_done(1, 200);
    check("start_latency", start_log[0] - wr_cyc, 2);

    // Overflow, then eight contiguous frames
    wr(32'h0, 32'd0);
    for (int i = 0; i < 9; i++) push_byte(8'h10 + 8'(i), 4, i < 8);
    rd_check("status_full_ovf", 32'h4, 32'h0000_008A);
    wr(32'h4, 32'h8);
    rd_check("status_ovf_clr", 32'h4, 32'h0000_0082);
    n0 = start_log.size();
    d0 = frames_done;
    wr(32'h0, 32'd1);
    wait_done(d0 + 8, 8 * 40 + 100);
    for (int i = 0; i < 7; i++) check("frame_gap", start_log[n0+i+1] - start_log[n0+i], 40);
    repeat (60) sync();
    rd_check("status_drained", 32'h4, 32'h0000_0004);
    check("sb_empty", sb.size(), 0);

    // Interrupt behaviour
    wr(32'h0, 32'd3);
    @(negedge clk);
    check("irq_idle_empty", irq_o, 1'b1);
    sync();
    d0 = frames_done;
    push_byte(8'h3C, 4, 1'b1);
    addr_i  = 32'h4;
    irq_bad = 0;
    seen    = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (data_o[0]) begin
        seen = 1'b1;
        if (irq_o !== 1'b0) irq_bad++;
      end else if (seen) begin
        check("irq_after_stop", irq_o, 1'b1);
        break;
      end
    end
    sync();
    addr_i = '0;
    check("irq_while_busy", irq_bad, 0);
    wait_done(d0 + 1, 100);
    wr(32'h0, 32'd1);
    @(negedge clk);
    check("irq_disabled", irq_o, 1'b0);
    sync();

    // BAUD change during the first of two frames
    n0 = frames_started;
    d0 = frames_done;
    push_byte(8'h5A, 4, 1'b1);
    push_byte(8'hC3, 8, 1'b1);
    wait_start(n0 + 1, 50);
    wr(32'h8, 32'd8);
    wait_done(d0 + 2, 300);
    check("baud_gap", start_log[n0+1] - start_log[n0], 40);
    rd_check("baud_readback", 32'h8, 32'h0000_0008);

    // Reset in the middle of the data bits
    n0 = frames_started;
    push_byte(8'h96, 8, 1'b1);
    push_byte(8'h69, 8, 1'b1);
    wait_start(n0 + 1, 50);
    repeat (24) sync();
    rst = 1'b0;
    sync();
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_tx", tx_o, 1'b1);
    check("rst_mid_irq", irq_o, 1'b0);
    sync();
    sb.delete();
    rd_check("rst_mid_ctrl", 32'h0, 32'h0);
    rd_check("rst_mid_status", 32'h4, 32'h0000_0004);
    rd_check("rst_mid_baud", 32'h8, 32'h0000_01B2);
    n0 = frames_started;
    repeat (300) sync();
    check("no_tx_after_rst", frames_started, n0);
    @(negedge clk);
    check("idle_tx_after_rst", tx_o, 1'b1);
    sync();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
